rpn_stack_calc: RTL and testbench

- Parametrised successor to the lab-7 two-operand calculator.
- Operands are pushed onto an internal LIFO stack of configurable depth and width. Opcodes entered through the same DataIn/Enter pair consume stack entries and push the result.
- Drives the display value (top of stack), ALU flags and a status code for the board's 7-segment and LED logic.

---
 rtl/rpn_stack_calc.sv | 179 +++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_calc.sv
// RPN calculator: a LIFO operand stack with a small ALU, driven by rising edges of Enter.
// Opcodes consume the top two entries and push the result; errors leave the stack untouched.
module rpn_stack_calc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         Enter,
    input  logic                         IsOp,
    input  logic [WIDTH-1:0]             DataIn,
    output logic [WIDTH-1:0]             ToDisplay,
    output logic [4:0]                   Flags,
    output logic [2:0]                   Status,
    output logic [$clog2(DEPTH+1)-1:0]   Depth
);
    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [DW-1:0] DepthMax = DW'(DEPTH);
    localparam logic [DW-1:0] One = DW'(1);
    localparam logic [DW-1:0] Two = DW'(2);

    typedef enum logic [2:0] {
        StEmpty   = 3'd0,
        StPartial = 3'd1,
        StFull    = 3'd2,
        StResult  = 3'd3,
        StError   = 3'd4
    } state_e;

    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];
    logic [DW-1:0]    depth_q, depth_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic             err_q, err_d;
    state_e           state_q, state_d;
    logic             enter_q;

    logic             ev;
    logic [IW-1:0]    top_idx, sec_idx, push_idx;
    logic [WIDTH-1:0] a, b, res;
    logic [WIDTH:0]   sum, diff;
    logic             c_flag, v_flag, fail;

    function automatic state_e level_state(input logic [DW-1:0] d);
        if (d == '0) begin
            return StEmpty;
        end else if (d == DepthMax) begin
            return StFull;
        end
        return StPartial;
    endfunction

    assign ev       = Enter & ~enter_q;
    // Entry i holds the (i+1)-th pushed value, so the top lives at depth-1.
    assign top_idx  = IW'(depth_q - One);
    assign sec_idx  = IW'(depth_q - Two);
    assign push_idx = IW'(depth_q);
    assign a        = stk_q[sec_idx];
    assign b        = stk_q[top_idx];
    assign sum      = {1'b0, a} + {1'b0, b};
    assign diff     = {1'b0, a} - {1'b0, b};

    always_comb begin
        stk_d   = stk_q;
        depth_d = depth_q;
        nzcv_d  = nzcv_q;
        err_d   = err_q;
        state_d = state_q;
        res     = '0;
        c_flag  = 1'b0;
        v_flag  = 1'b0;
        fail    = 1'b0;
        if (ev) begin
            if (state_q == StError) begin
                // Acknowledge only: inputs are ignored for this event.
                err_d   = 1'b0;
                state_d = level_state(depth_q);
            end else begin
                if (!IsOp) begin
                    if (depth_q == DepthMax) begin
                        fail = 1'b1;
                    end else begin
                        stk_d[push_idx] = DataIn;
                        depth_d         = depth_q + One;
                        state_d         = level_state(depth_d);
                    end
                end else begin
                    case (DataIn[2:0])
                        3'd5: begin
                            if (depth_q == '0 || depth_q == DepthMax) begin
                                fail = 1'b1;
                            end else begin
                                stk_d[push_idx] = b;
                                depth_d         = depth_q + One;
                                state_d         = level_state(depth_d);
                            end
                        end
                        3'd6: begin
                            if (depth_q == '0) begin
                                fail = 1'b1;
                            end else begin
                                depth_d = depth_q - One;
                                state_d = level_state(depth_d);
                            end
                        end
                        3'd7: begin
                            if (depth_q < Two) begin
                                fail = 1'b1;
                            end else begin
                                stk_d[sec_idx] = b;
                                stk_d[top_idx] = a;
                                state_d        = level_state(depth_q);
                            end
                        end
                        default: begin
                            if (depth_q < Two) begin
                                fail = 1'b1;
                            end else begin
                                case (DataIn[2:0])
                                    3'd0: begin
                                        res    = sum[WIDTH-1:0];
                                        c_flag = sum[WIDTH];
                                        v_flag = (a[WIDTH-1] == b[WIDTH-1]) &&
                                                 (res[WIDTH-1] != a[WIDTH-1]);
                                    end
                                    3'd1: begin
                                        res    = diff[WIDTH-1:0];
                                        c_flag = diff[WIDTH];
                                        v_flag = (a[WIDTH-1] != b[WIDTH-1]) &&
                                                 (res[WIDTH-1] != a[WIDTH-1]);
                                    end
                                    3'd2:    res = a & b;
                                    3'd3:    res = a | b;
                                    default: res = a ^ b;
                                endcase
                                stk_d[sec_idx] = res;
                                depth_d        = depth_q - One;
                                nzcv_d         = {res[WIDTH-1], res == '0, c_flag, v_flag};
                                state_d        = StResult;
                            end
                        end
                    endcase
                end
                // Failing branches touch nothing, so only ERR and state need setting.
                if (fail) begin
                    err_d   = 1'b1;
                    state_d = StError;
                end else begin
                    err_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stk_q   <= '{default: '0};
            depth_q <= '0;
            nzcv_q  <= '0;
            err_q   <= 1'b0;
            state_q <= StEmpty;
            enter_q <= 1'b1;
        end else begin
            stk_q   <= stk_d;
            depth_q <= depth_d;
            nzcv_q  <= nzcv_d;
            err_q   <= err_d;
            state_q <= state_d;
            enter_q <= Enter;
        end
    end

    assign ToDisplay = (depth_q == '0) ? '0 : b;
    assign Flags     = {err_q, nzcv_q};
    assign Status    = state_q;
    assign Depth     = depth_q;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Scoreboard bench for rpn_stack_calc: stimulus queues expected results from a queue-based
// stack model; an independent monitor compares them whenever it sees an Enter event commit.
module tb_rpn_stack_calc;
    localparam int W = 16;
    localparam int D = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          Enter = 1'b0;
    logic          IsOp = 1'b0;
    logic [W-1:0]  DataIn = '0;
    logic [W-1:0]  ToDisplay;
    logic [4:0]    Flags;
    logic [2:0]    Status;
    logic [2:0]    Depth;

    always #5 clk = ~clk;

    rpn_stack_calc #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .Enter     (Enter),
        .IsOp      (IsOp),
        .DataIn    (DataIn),
        .ToDisplay (ToDisplay),
        .Flags     (Flags),
        .Status    (Status),
        .Depth     (Depth)
    );

    typedef struct packed {
        logic [15:0] disp;
        logic [4:0]  flags;
        logic [2:0]  status;
        logic [2:0]  depth;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;

    logic [15:0] mstk[$];
    logic        m_err, m_n, m_z, m_c, m_v, m_result;

    function automatic void model_reset();
        mstk.delete();
        m_err = 0; m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_result = 0;
    endfunction

    function automatic exp_t model_snapshot();
        exp_t e;
        int   n = mstk.size();
        e.disp  = (n > 0) ? mstk[n-1] : 16'h0;
        e.flags = {m_err, m_n, m_z, m_c, m_v};
        if (m_err)         e.status = 3'd4;
        else if (m_result) e.status = 3'd3;
        else if (n == 0)   e.status = 3'd0;
        else if (n == D)   e.status = 3'd2;
        else               e.status = 3'd1;
        e.depth = 3'(n);
        return e;
    endfunction

    function automatic void model_apply(input bit isop, input logic [15:0] d);
        int          n = mstk.size();
        logic [15:0] a, b, r;
        int          s, sa, sb, ss;
        bit          ok = 1;
        bit          binop = 0;
        if (m_err) begin
            m_err = 0;
            m_result = 0;
            return;
        end
        if (!isop) begin
            if (n < D) mstk.push_back(d);
            else ok = 0;
        end else begin
            case (d[2:0])
                3'd5: if (n >= 1 && n < D) mstk.push_back(mstk[n-1]); else ok = 0;
                3'd6: if (n >= 1) void'(mstk.pop_back()); else ok = 0;
                3'd7: begin
                    if (n >= 2) begin
                        a = mstk[n-2];
                        mstk[n-2] = mstk[n-1];
                        mstk[n-1] = a;
                    end else ok = 0;
                end
                default: begin
                    if (n >= 2) begin
                        a  = mstk[n-2];
                        b  = mstk[n-1];
                        sa = int'($signed(a));
                        sb = int'($signed(b));
                        m_c = 0;
                        m_v = 0;
                        case (d[2:0])
                            3'd0: begin
                                s = int'(a) + int'(b);
                                ss = sa + sb;
                                r = 16'(s);
                                m_c = (s > 65535);
                                m_v = (ss > 32767) || (ss < -32768);
                            end
                            3'd1: begin
                                s = int'(a) - int'(b);
                                ss = sa - sb;
                                r = 16'(s);
                                m_c = (a < b);
                                m_v = (ss > 32767) || (ss < -32768);
                            end
                            3'd2:    r = a & b;
                            3'd3:    r = a | b;
                            default: r = a ^ b;
                        endcase
                        void'(mstk.pop_back());
                        mstk[n-2] = r;
                        m_n = r[15];
                        m_z = (r == 16'h0);
                        binop = 1;
                    end else ok = 0;
                end
            endcase
        end
        if (!ok) m_err = 1;
        else m_result = binop;
    endfunction

    task automatic cmp(input string name, input exp_t got, input exp_t want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got disp=%h flags=%b status=%0d depth=%0d, required disp=%h flags=%b status=%0d depth=%0d",
                     name, got.disp, got.flags, got.status, got.depth,
                     want.disp, want.flags, want.status, want.depth);
        end
    endtask

    function automatic exp_t dut_view();
        return {ToDisplay, Flags, Status, Depth};
    endfunction

    // Monitor: tracks Enter edges independently of the stimulus and checks after each commit.
    initial begin : monitor
        logic mon_enter_q;
        logic ev;
        exp_t want;
        mon_enter_q = 1'b1;
        forever begin
            @(posedge clk);
            ev = Enter && !mon_enter_q && !reset;
            mon_enter_q = reset ? 1'b1 : Enter;
            if (ev) begin
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got an event with no expectation queued, required none");
                end else begin
                    want = exp_q.pop_front();
                    cmp("event", dut_view(), want);
                end
            end
        end
    end

    task automatic ev_op(input bit isop, input logic [15:0] d, input int hold = 1);
        @(negedge clk);
        IsOp = isop;
        DataIn = d;
        Enter = 1'b1;
        model_apply(isop, d);
        exp_q.push_back(model_snapshot());
        repeat (hold) @(negedge clk);
        Enter = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        Enter = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_now(input string name);
        cmp(name, dut_view(), model_snapshot());
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();
        check_now("reset_state");
        cmp("reset_const", dut_view(), exp_t'({16'h0, 5'b00000, 3'd0, 3'd0}));

        ev_op(0, 16'd10); ev_op(0, 16'd5); ev_op(1, 16'd1);
        @(negedge clk);
        cmp("plan_sub", dut_view(), exp_t'({16'd5, 5'b00000, 3'd3, 3'd1}));

        do_reset();
        ev_op(0, 16'd2); ev_op(0, 16'hFFFE); ev_op(1, 16'd0);
        @(negedge clk);
        cmp("plan_add_zc", dut_view(), exp_t'({16'h0000, 5'b00110, 3'd3, 3'd1}));
        ev_op(0, 16'h7FFF); ev_op(0, 16'h0001); ev_op(1, 16'd0);
        @(negedge clk);
        cmp("plan_add_nv", dut_view(), exp_t'({16'h8000, 5'b01001, 3'd3, 3'd2}));

        do_reset();
        ev_op(0, 16'd2); ev_op(1, 16'd0);
        @(negedge clk);
        cmp("plan_underflow", dut_view(), exp_t'({16'd2, 5'b10000, 3'd4, 3'd1}));
        ev_op(0, 16'd9);
        @(negedge clk);
        cmp("plan_err_clear", dut_view(), exp_t'({16'd2, 5'b00000, 3'd1, 3'd1}));

        do_reset();
        ev_op(0, 16'd1); ev_op(0, 16'd2); ev_op(0, 16'd3); ev_op(0, 16'd4);
        ev_op(0, 16'd5);
        @(negedge clk);
        cmp("plan_overflow", dut_view(), exp_t'({16'd4, 5'b10000, 3'd4, 3'd4}));

        do_reset();
        ev_op(0, 16'd3); ev_op(0, 16'd7); ev_op(1, 16'd7); ev_op(1, 16'd5);
        @(negedge clk);
        cmp("plan_swap_dup", dut_view(), exp_t'({16'd3, 5'b00000, 3'd1, 3'd3}));

        do_reset();
        ev_op(0, 16'd8, 6);
        @(negedge clk);
        cmp("held_enter", dut_view(), exp_t'({16'd8, 5'b00000, 3'd1, 3'd1}));

        // Enter rises while reset is held and stays high after release.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); Enter = 1'b1; IsOp = 1'b0; DataIn = 16'd6;
        @(negedge clk); reset = 1'b0; model_reset();
        repeat (3) @(negedge clk);
        Enter = 1'b0;
        cmp("enter_through_reset", dut_view(), exp_t'({16'h0, 5'b00000, 3'd0, 3'd0}));

        ev_op(0, 16'd11);
        @(negedge clk); reset = 1'b1; Enter = 1'b1; IsOp = 1'b0; DataIn = 16'd5;
        @(negedge clk); reset = 1'b0; Enter = 1'b0; model_reset();
        cmp("enter_same_as_reset", dut_view(), exp_t'({16'h0, 5'b00000, 3'd0, 3'd0}));

        for (int i = 0; i < 500; i++) begin
            bit          isop;
            logic [15:0] d;
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
                check_now("rand_reset");
            end
            isop = ($urandom_range(0, 99) < 55);
            d = 16'($urandom);
            if ($urandom_range(0, 3) == 0) d = {$urandom_range(0, 1) ? 8'hFF : 8'h7F, 8'($urandom)};
            ev_op(isop, d, $urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check_now("final_state");
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d unchecked expectations, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
